// File: rtl/mbgd_phase1_ctrl.sv
// MBGD forward-pass batch sequencer: streams samples through phase1 and emits per-sample h - y.
// Optional batch error accumulator is enabled by defining MBGD_ERR_ACC_EN.
module mbgd_phase1_ctrl #(
    parameter int unsigned DW     = 8,
    parameter int unsigned N      = 8,
    parameter int unsigned BATCH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LAT    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [N*DW-1:0]     teta_in,
    output logic                smp_rd,
    output logic [ADDR_W-1:0]   smp_addr,
    input  logic [N*DW-1:0]     smp_x,
    input  logic [7:0]          smp_y,
    output logic                p1_enable,
    output logic [N*DW-1:0]     p1_x,
    output logic [N*DW-1:0]     p1_teta,
    input  logic [7:0]          p1_h,
    output logic                err_valid,
    output logic [8:0]          err_data,
    output logic [ADDR_W-1:0]   err_idx,
    output logic [ADDR_W+8:0]   err_sum,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DEPTH = LAT + 2;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic [N*DW-1:0]     r_p1_x;
    logic [N*DW-1:0]     r_teta;
    logic [DEPTH-1:0]    r_vld;
    logic [ADDR_W-1:0]   r_idx [DEPTH];
    logic [7:0]          r_lbl [1:DEPTH-1];
    logic                r_err_valid;
    logic [8:0]          r_err_data;
    logic [ADDR_W-1:0]   r_err_idx;
    logic                w_start;
    logic                w_issue;
    logic [8:0]          w_err;

    assign w_start = (r_state == StIdle) && start;
    assign w_issue = (r_state == StIssue);
    assign w_err   = {1'b0, p1_h} - {1'b0, r_lbl[DEPTH-1]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StIssue;
            StIssue: if (r_rd_cnt == ADDR_W'(BATCH - 1)) w_state_nxt = StDrain;
            StDrain: if (r_out_cnt == CNT_W'(BATCH)) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt    <= '0;
            r_out_cnt   <= '0;
            r_p1_x      <= '0;
            r_teta      <= '0;
            r_vld       <= '0;
            r_err_valid <= 1'b0;
            r_err_data  <= '0;
            r_err_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
            for (int i = 1; i < DEPTH; i++) r_lbl[i] <= '0;
        end else if (enable) begin
            if (w_start) begin
                r_teta    <= teta_in;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
                if (r_vld[DEPTH-1]) r_out_cnt <= r_out_cnt + 1'b1;
            end
            r_p1_x   <= smp_x;
            // Tag line: stage k holds the sample read k+1 enabled cycles ago.
            r_vld    <= {r_vld[DEPTH-2:0], w_issue};
            r_idx[0] <= r_rd_cnt;
            r_lbl[1] <= smp_y;
            for (int i = 1; i < DEPTH; i++) r_idx[i] <= r_idx[i-1];
            for (int i = 2; i < DEPTH; i++) r_lbl[i] <= r_lbl[i-1];
            r_err_valid <= r_vld[DEPTH-1];
            if (r_vld[DEPTH-1]) begin
                r_err_data <= w_err;
                r_err_idx  <= r_idx[DEPTH-1];
            end
        end
    end

`ifdef MBGD_ERR_ACC_EN
    logic [ADDR_W+8:0] r_err_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_sum <= '0;
        end else if (enable) begin
            if (w_start) begin
                r_err_sum <= '0;
            end else if (r_err_valid) begin
                r_err_sum <= r_err_sum + {{ADDR_W{r_err_data[8]}}, r_err_data};
            end
        end
    end

    assign err_sum = r_err_sum;
`else
    assign err_sum = '0;
`endif

    assign smp_rd    = w_issue && enable;
    assign smp_addr  = r_rd_cnt;
    assign p1_enable = enable;
    assign p1_x      = r_p1_x;
    assign p1_teta   = r_teta;
    assign err_valid = r_err_valid;
    assign err_data  = r_err_data;
    assign err_idx   = r_err_idx;
    assign busy      = (r_state == StIssue) || (r_state == StDrain);
    assign done      = (r_state == StDone);

endmodule

// File: tb/tb_mbgd_phase1_ctrl.sv
// Directed bench for mbgd_phase1_ctrl with a registered sample memory and a 4-stage phase1 model
// (h = x[7:0] + teta[7:0]). Define MBGD_ERR_ACC_EN to also check the batch error sum.
module tb_mbgd_phase1_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned BATCH  = 16;

    logic              clk = 1'b0;
    logic              reset, enable, start;
    logic [63:0]       teta_in;
    logic              smp_rd;
    logic [ADDR_W-1:0] smp_addr;
    logic [63:0]       smp_x = '0;
    logic [7:0]        smp_y = '0;
    logic              p1_enable;
    logic [63:0]       p1_x, p1_teta;
    logic [7:0]        p1_h;
    logic              err_valid;
    logic [8:0]        err_data;
    logic [ADDR_W-1:0] err_idx;
    logic [ADDR_W+8:0] err_sum;
    logic              busy, done;

    logic [7:0] mem_x [BATCH];
    logic [7:0] mem_y [BATCH];
    logic [7:0] pp0 = '0, pp1 = '0, pp2 = '0, pp3 = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mbgd_phase1_ctrl #(
        .DW(8), .N(8), .BATCH(BATCH), .ADDR_W(ADDR_W), .LAT(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .teta_in(teta_in),
        .smp_rd(smp_rd), .smp_addr(smp_addr), .smp_x(smp_x), .smp_y(smp_y),
        .p1_enable(p1_enable), .p1_x(p1_x), .p1_teta(p1_teta), .p1_h(p1_h),
        .err_valid(err_valid), .err_data(err_data), .err_idx(err_idx), .err_sum(err_sum),
        .busy(busy), .done(done)
    );

    // Sample memory: output updates only on a read strobe, otherwise holds.
    always @(posedge clk) begin
        if (smp_rd) begin
            smp_x <= {56'd0, mem_x[smp_addr]};
            smp_y <= mem_y[smp_addr];
        end
    end

    always @(posedge clk) begin
        if (p1_enable) begin
            pp0 <= p1_x[7:0] + p1_teta[7:0];
            pp1 <= pp0;
            pp2 <= pp1;
            pp3 <= pp2;
        end
    end
    assign p1_h = pp3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for nominal batch cycle n (start seen in cycle 0, enable high throughout).
    task automatic chk(input int c, input int n, input logic en, input logic [7:0] t);
        logic       exp_rd, exp_ev;
        logic [7:0] h;
        logic [8:0] e;
        logic [12:0] s;
        string      p;
        p = $sformatf("c%0d/n%0d", c, n);
        exp_rd = en && (n >= 1) && (n <= BATCH);
        check({p, " smp_rd"}, 64'(smp_rd), 64'(exp_rd));
        if (exp_rd) check({p, " smp_addr"}, 64'(smp_addr), 64'(n - 1));
        exp_ev = (n >= 8) && (n <= 23);
        check({p, " err_valid"}, 64'(err_valid), 64'(exp_ev));
        if (exp_ev) begin
            h = mem_x[n-8] + t;
            e = {1'b0, h} - {1'b0, mem_y[n-8]};
            check({p, " err_idx"}, 64'(err_idx), 64'(n - 8));
            check({p, " err_data"}, 64'(err_data), 64'(e));
        end
        check({p, " busy"}, 64'(busy), 64'((n >= 1) && (n <= 23)));
        check({p, " done"}, 64'(done), 64'(n == 24));
        if (n == 24) begin
            s = '0;
            for (int i = 0; i < BATCH; i++) begin
                h = mem_x[i] + t;
                e = {1'b0, h} - {1'b0, mem_y[i]};
                s = s + {{4{e[8]}}, e};
            end
`ifdef MBGD_ERR_ACC_EN
            check({p, " err_sum"}, 64'(err_sum), 64'(s));
`else
            check({p, " err_sum"}, 64'(err_sum), 64'd0);
`endif
        end
    endtask

    // Called just after a negedge; that cycle is batch cycle 0.
    task automatic run_batch(input logic [7:0] t, input bit stall, input bit disturb,
                             input int hand);
        logic en;
        int   n;
        teta_in = {56'h0123_4567_89AB_CD, t};
        start   = 1'b1;
        enable  = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            start = disturb && (c == 6);
            if (disturb && c == 3) teta_in = {56'hFEDC_BA98_7654_32, 8'h77};
            en = !(stall && c >= 5 && c <= 7);
            enable = en;
            #1;
            n = (!stall || c <= 5) ? c : ((c <= 8) ? 5 : c - 3);
            chk(c, n, en, t);
            if (disturb && c == 10) check("p1_teta held", p1_teta, {56'h0123_4567_89AB_CD, t});
            if (hand == 1 && c == 8) check("hand h200-y255", 64'(err_data), 64'h1C9);
            if (hand == 1 && c == 9) check("hand h10-y0", 64'(err_data), 64'h00A);
            if (hand == 2 && n == 24) begin
`ifdef MBGD_ERR_ACC_EN
                check("hand err_sum 4080", 64'(err_sum), 64'd4080);
`else
                check("hand err_sum off", 64'(err_sum), 64'd0);
`endif
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        start   = 1'b1;
        teta_in = 64'h1111_2222_3333_4444;
        for (int i = 0; i < BATCH; i++) begin
            mem_x[i] = 8'(i * 37 + 11);
            mem_y[i] = 8'(i * 53 + 5);
        end
        mem_x[0] = 8'd200; mem_y[0] = 8'd255;
        mem_x[1] = 8'd10;  mem_y[1] = 8'd0;

        // Reset held two cycles with start high.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("rst smp_rd", 64'(smp_rd), 64'd0);
            check("rst smp_addr", 64'(smp_addr), 64'd0);
            check("rst busy", 64'(busy), 64'd0);
            check("rst done", 64'(done), 64'd0);
            check("rst err_valid", 64'(err_valid), 64'd0);
            check("rst err_data", 64'(err_data), 64'd0);
            check("rst err_idx", 64'(err_idx), 64'd0);
            check("rst err_sum", 64'(err_sum), 64'd0);
            check("rst p1_x", p1_x, 64'd0);
            check("rst p1_teta", p1_teta, 64'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("idle busy", 64'(busy), 64'd0);
        check("idle smp_rd", 64'(smp_rd), 64'd0);
        check("idle p1_enable", 64'(p1_enable), 64'd1);

        // Nominal batch with hand-checked arithmetic.
        run_batch(8'h00, 1'b0, 1'b0, 1);
        // Late start pulse and teta_in change are ignored.
        run_batch(8'h05, 1'b0, 1'b1, 0);
        // Three-cycle enable stall.
        run_batch(8'h30, 1'b1, 1'b0, 0);

        // Reset mid-batch, restart two cycles later.
        teta_in = {56'h0123_4567_89AB_CD, 8'h11};
        start   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 12);
            reset = (c == 10);
            #1;
            if (c <= 10) begin
                chk(c, c, 1'b1, 8'h11);
            end else begin
                check($sformatf("post-rst c%0d busy", c), 64'(busy), 64'd0);
                check($sformatf("post-rst c%0d err_valid", c), 64'(err_valid), 64'd0);
                check($sformatf("post-rst c%0d smp_rd", c), 64'(smp_rd), 64'd0);
            end
        end
        for (int c = 13; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk(c, c - 12, 1'b1, 8'h11);
        end

        // All samples give h=255, y=0.
        for (int i = 0; i < BATCH; i++) begin
            mem_x[i] = 8'd255;
            mem_y[i] = 8'd0;
        end
        run_batch(8'h00, 1'b0, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mbgd_phase1_ctrl.md
Name: mbgd_phase1_ctrl

Overview:
Batch sequencer for the MBGD forward pass. On a start pulse it latches the current teta and streams BATCH samples from sample memory through the phase1 hypothesis datapath (x, teta to h) at one sample per cycle. It delays each label y to match the datapath latency and emits a per-sample signed error e = h - y, with an index, for the gradient stage. It sits between sample memory, phase1 and the gradient/update block.

Parameters:
DW, 8, feature/weight element width
N, 8, features per sample (x and teta are N*DW = 64 bits)
BATCH, 16, samples per mini-batch
ADDR_W, 4, sample memory address width, >= clog2(BATCH)
LAT, 4, phase1 latency: cycles from p1_x/p1_teta valid to p1_h valid, with p1_enable held high

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  global advance; low freezes the whole block and phase1
start  in  1  one-cycle pulse that begins a batch; ignored unless IDLE
teta_in  in  64  current weights
smp_rd  out  1  sample memory read strobe
smp_addr  out  ADDR_W  sample index
smp_x  in  64  sample features, valid 1 cycle after smp_rd
smp_y  in  8  label (0..255), valid 1 cycle after smp_rd
p1_enable  out  1  phase1 enable
p1_x  out  64  features to phase1
p1_teta  out  64  latched weights to phase1
p1_h  in  8  phase1 hypothesis output
err_valid  out  1  err_data/err_idx valid
err_data  out  9  signed h - y
err_idx  out  ADDR_W  sample index of err_data
err_sum  out  ADDR_W+9  signed batch error sum (see Optional Feature)
busy  out  1  batch in progress
done  out  1  one-cycle pulse after the last error

Behaviour:
- Reset (synchronous, active-high) sets state IDLE and clears all counters, the valid/label delay lines and the teta register. All outputs are 0.
- A reset mid-batch abandons the batch. In-flight phase1 results never produce err_valid because the valid line is cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE to ISSUE on start with enable high. teta_in is latched into p1_teta on that edge.
  - ISSUE: smp_rd=1, smp_addr = rd_cnt, rd_cnt increments each cycle. After issuing address BATCH-1 the FSM moves to DRAIN.
  - DRAIN: wait until out_cnt == BATCH, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in ISSUE and DRAIN.
- Pipeline timing, for a read in cycle t with enable high throughout:
  - smp_x/smp_y are registered into p1_x and the y delay line, visible at t+2.
  - p1_h is valid at t+2+LAT.
  - err_data = zero-extended p1_h minus zero-extended y (9-bit two's complement, range -255..255, no saturation). It is registered and visible with err_valid at t+3+LAT.
  - err_idx equals the issuing address.
- Valid tracking uses a (LAT+2)-deep shift register tagged with the sample index and label. No combinational path from p1_h to outputs other than through this register.
- p1_enable = enable.
- enable low: every register holds (FSM, counters, delay lines, outputs), smp_rd is forced 0 and err_valid holds its value without re-counting. The sample is counted once, on the enable-high edge.
- start while busy or in DONE is ignored. teta_in changes after latching do not affect p1_teta until the next batch.
- BATCH=1 is legal: ISSUE lasts 1 cycle.

Optional Feature:
Macro MBGD_ERR_ACC_EN.
- Defined: err_sum is cleared at batch start and accumulates sign-extended err_data on each counted err_valid. It is stable and valid in the done cycle and held until the next start.
- Undefined: err_sum is tied to 0 and no accumulator logic exists.

Test Plan:
1. Reset: assert reset 2 cycles with start=1 -> all outputs 0, state IDLE, no smp_rd.
2. Defaults, start at cycle 0, enable=1 -> smp_rd cycles 1..16 with addr 0..15; err_valid cycles 8..23 with err_idx 0..15; done at cycle 24; busy cycles 1..23.
3. Arithmetic: the model drives (h=200, y=255) and (h=10, y=0) -> err_data 0x1C9 (-55) and 0x00A; with MBGD_ERR_ACC_EN, a batch of all (h=255, y=0) -> err_sum=4080 at done.
4. enable low for 3 cycles at cycle 5 -> the issued and returned sequences are identical but shifted by 3; no duplicate or lost err_idx; done at cycle 27.
5. start pulse at cycle 6 and teta_in change at cycle 3 -> ignored; p1_teta keeps its cycle-0 value; a single done.
6. reset at cycle 10, then start at cycle 12 -> busy=0 and err_valid=0 from cycle 11; no stale errors; the new batch follows scenario 2 timing offset by 12.
